cpu_bus_arbiter: RTL and testbench

- Shares the CPU's single memory-bus master port between the instruction-fetch requester (IF) and the load/store requester (MEM).
- Sequences every access through one FSM and owns generation of `bus_stall` for the whole pipeline.
- Holds a jump flush that arrives while the pipeline is stalled and releases it on the first non-stalled cycle. This prevents the IF/ID flush from being masked by the stall.

---
 rtl/cpu_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_cpu_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter
// Shares the CPU's single memory-bus master port between the instruction-fetch
// requester (IF) and the load/store requester (MEM). It also generates the
// pipeline-wide bus_stall, and it holds a jump flush that arrives during a stall.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   if_req/if_addr     fetch request (level) and address
//   if_rdata/if_done   fetched word (held) and one-cycle completion pulse
//   dm_req/dm_we/...   load/store request, strobes, address, store data
//   dm_rdata/dm_done   load data (held) and one-cycle completion pulse
//   bus_*              master-side bus request; bus_ready/bus_rdata from the bus
//   bus_stall          freeze all pipeline registers
//   jump_req           taken branch/jump from EX
//   jump_flush         flush IF/ID and ID/EX
module cpu_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_done,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [DATA_W/8-1:0]   dm_wstrb,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_done,
    output logic                  bus_valid,
    output logic                  bus_write,
    output logic [DATA_W/8-1:0]   bus_strb,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_ready,
    input  logic [DATA_W-1:0]     bus_rdata,
    output logic                  bus_stall,
    input  logic                  jump_req,
    output logic                  jump_flush
);

    typedef enum logic [1:0] {
        IDLE,
        IF_ACC,
        DM_ACC,
        DONE
    } state_t;

    state_t state;
    logic   if_served;
    logic   dm_served;
    logic   pending_jump;
    logic   last_grant;     // 0 = IF was granted last, 1 = MEM
    logic   if_elig;
    logic   dm_elig;
    logic   grant_dm;
    logic   grant_if;

    // A served port keeps its request raised while the pipeline is frozen,
    // so the served flag masks it until the pipeline moves again.
    assign if_elig  = if_req & ~if_served;
    assign dm_elig  = dm_req & ~dm_served;
    assign grant_dm = dm_elig & (~if_elig | ~last_grant);
    assign grant_if = if_elig & (~dm_elig | last_grant);

    assign bus_stall  = (if_req & ~if_served & ~if_done) |
                        (dm_req & ~dm_served & ~dm_done);
    assign jump_flush = (jump_req | pending_jump) & ~bus_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            bus_valid    <= 1'b0;
            bus_write    <= 1'b0;
            bus_strb     <= '0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            if_done      <= 1'b0;
            dm_done      <= 1'b0;
            if_rdata     <= '0;
            dm_rdata     <= '0;
            if_served    <= 1'b0;
            dm_served    <= 1'b0;
            pending_jump <= 1'b0;
            last_grant   <= 1'b0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;

            // An unstalled cycle lets the pipeline advance, so any request seen
            // next cycle is a new one; clearing wins over the DONE-cycle set.
            if (!bus_stall) begin
                if_served <= 1'b0;
                dm_served <= 1'b0;
            end else begin
                if (if_done) if_served <= 1'b1;
                if (dm_done) dm_served <= 1'b1;
            end

            if (jump_flush)
                pending_jump <= 1'b0;
            else if (jump_req && bus_stall)
                pending_jump <= 1'b1;

            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        bus_valid  <= 1'b1;
                        bus_write  <= dm_we;
                        bus_strb   <= dm_we ? dm_wstrb : '1;
                        bus_addr   <= dm_addr;
                        bus_wdata  <= dm_wdata;
                        last_grant <= 1'b1;
                        state      <= DM_ACC;
                    end else if (grant_if) begin
                        bus_valid  <= 1'b1;
                        bus_write  <= 1'b0;
                        bus_strb   <= '1;
                        bus_addr   <= if_addr;
                        bus_wdata  <= '0;
                        last_grant <= 1'b0;
                        state      <= IF_ACC;
                    end
                end
                IF_ACC: begin
                    if (bus_ready) begin
                        if_rdata  <= bus_rdata;
                        bus_valid <= 1'b0;
                        if_done   <= 1'b1;
                        state     <= DONE;
                    end
                end
                DM_ACC: begin
                    if (bus_ready) begin
                        if (!bus_write) dm_rdata <= bus_rdata;
                        bus_valid <= 1'b0;
                        dm_done   <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter: directed scenarios with literal
// expectations followed by randomized traffic checked every cycle against a
// behavioural model of the arbitration rules.
module tb_cpu_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          dm_req;
    logic          dm_we;
    logic [3:0]    dm_wstrb;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;
    logic          bus_valid;
    logic          bus_write;
    logic [3:0]    bus_strb;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ready;
    logic [DW-1:0] bus_rdata;
    logic          bus_stall;
    logic          jump_req;
    logic          jump_flush;

    always #5 clk = ~clk;

    cpu_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_wstrb(dm_wstrb), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done),
        .bus_valid(bus_valid), .bus_write(bus_write), .bus_strb(bus_strb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
        .bus_rdata(bus_rdata), .bus_stall(bus_stall),
        .jump_req(jump_req), .jump_flush(jump_flush)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_port;        // port owning the bus: 0 none, 1 IF, 2 MEM
    bit          m_on_bus;      // access presented on the bus
    bit          m_completing;  // completion-pulse cycle
    bit          m_prefer_dm;   // MEM wins a tie (IF went last)
    bit          m_if_srv, m_dm_srv, m_pend, m_stall_seen;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
    logic [3:0]  m_strb;
    bit          m_write;
    bit          e_if_done, e_dm_done, e_stall, e_flush, want_if, want_dm;

    task automatic model_reset();
        m_port = 0; m_on_bus = 0; m_completing = 0; m_prefer_dm = 1;
        m_if_srv = 0; m_dm_srv = 0; m_pend = 0; m_stall_seen = 0;
        m_addr = '0; m_wdata = '0; m_strb = '0; m_write = 0;
        m_if_rdata = '0; m_dm_rdata = '0;
    endtask

    always @(negedge rst) model_reset();

    always @(negedge clk) begin
        if (!rst) begin
            model_reset();
        end else begin
            e_if_done = m_completing && (m_port == 1);
            e_dm_done = m_completing && (m_port == 2);
            e_stall   = (if_req && !m_if_srv && !e_if_done) || (dm_req && !m_dm_srv && !e_dm_done);
            e_flush   = (jump_req || m_pend) && !e_stall;
            want_if   = if_req && !m_if_srv;
            want_dm   = dm_req && !m_dm_srv;

            chk("bus_valid", bus_valid, m_on_bus);
            if (m_on_bus) begin
                chk("bus_addr", bus_addr, m_addr);
                chk("bus_write", bus_write, m_write);
                chk("bus_strb", bus_strb, m_strb);
                if (m_write) chk("bus_wdata", bus_wdata, m_wdata);
            end
            chk("if_done", if_done, e_if_done);
            chk("dm_done", dm_done, e_dm_done);
            chk("if_rdata", if_rdata, m_if_rdata);
            chk("dm_rdata", dm_rdata, m_dm_rdata);
            chk("bus_stall", bus_stall, e_stall);
            chk("jump_flush", jump_flush, e_flush);

            // advance to the next cycle
            m_pend = e_flush ? 1'b0 : ((jump_req && e_stall) ? 1'b1 : m_pend);
            if (!e_stall) begin
                m_if_srv = 0; m_dm_srv = 0;
            end else begin
                if (e_if_done) m_if_srv = 1;
                if (e_dm_done) m_dm_srv = 1;
            end
            if (m_completing) begin
                m_completing = 0;
                m_port = 0;
            end else if (m_on_bus) begin
                if (bus_ready) begin
                    if (m_port == 1) m_if_rdata = bus_rdata;
                    else if (!m_write) m_dm_rdata = bus_rdata;
                    m_on_bus = 0;
                    m_completing = 1;
                end
            end else if (want_dm && (!want_if || m_prefer_dm)) begin
                m_port = 2; m_on_bus = 1; m_addr = dm_addr; m_write = dm_we;
                m_strb = dm_we ? dm_wstrb : 4'hF; m_wdata = dm_wdata; m_prefer_dm = 0;
            end else if (want_if) begin
                m_port = 1; m_on_bus = 1; m_addr = if_addr; m_write = 0;
                m_strb = 4'hF; m_wdata = '0; m_prefer_dm = 1;
            end
            m_stall_seen = e_stall;
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        rst = 0; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_wstrb = '0;
        dm_addr = '0; dm_wdata = '0; bus_ready = 0; bus_rdata = '0; jump_req = 0;
        repeat (2) neg();
        chk("rst bus_valid", bus_valid, 0);
        chk("rst bus_addr", bus_addr, 0);
        chk("rst bus_strb", bus_strb, 0);
        chk("rst if_rdata", if_rdata, 0);
        chk("rst dm_rdata", dm_rdata, 0);
        chk("rst if_done", if_done, 0);
        chk("rst dm_done", dm_done, 0);
        nxt(); rst = 1;

        // single load
        nxt(); dm_req = 1; dm_we = 0; dm_addr = 32'h100; bus_ready = 1; bus_rdata = 32'hDEADBEEF;
        neg(); chk("ld c0 stall", bus_stall, 1); chk("ld c0 valid", bus_valid, 0);
        nxt(); neg(); chk("ld c1 valid", bus_valid, 1); chk("ld c1 addr", bus_addr, 32'h100);
        chk("ld c1 stall", bus_stall, 1);
        nxt(); neg(); chk("ld c2 done", dm_done, 1); chk("ld c2 valid", bus_valid, 0);
        chk("ld c2 rdata", dm_rdata, 32'hDEADBEEF); chk("ld c2 stall", bus_stall, 0);
        nxt(); dm_req = 0; bus_ready = 0;
        neg(); chk("ld c3 done", dm_done, 0);

        // reset, then simultaneous IF + MEM
        nxt(); rst = 0;
        nxt(); rst = 1;
        nxt(); if_req = 1; if_addr = 32'h40; dm_req = 1; dm_we = 0; dm_addr = 32'h200;
        bus_ready = 1; bus_rdata = 32'h11111111;
        neg(); chk("sim c0 stall", bus_stall, 1);
        nxt(); neg(); chk("sim c1 valid", bus_valid, 1); chk("sim c1 addr", bus_addr, 32'h200);
        nxt(); neg(); chk("sim c2 dm_done", dm_done, 1); chk("sim c2 if_done", if_done, 0);
        chk("sim c2 stall", bus_stall, 1); chk("sim c2 dm_rdata", dm_rdata, 32'h11111111);
        nxt(); bus_rdata = 32'h22222222;
        neg(); chk("sim c3 valid", bus_valid, 0); chk("sim c3 stall", bus_stall, 1);
        nxt(); neg(); chk("sim c4 valid", bus_valid, 1); chk("sim c4 addr", bus_addr, 32'h40);
        nxt(); neg(); chk("sim c5 if_done", if_done, 1); chk("sim c5 dm_done", dm_done, 0);
        chk("sim c5 rdata", if_rdata, 32'h22222222); chk("sim c5 stall", bus_stall, 0);
        nxt(); if_req = 0; dm_req = 0; bus_ready = 0;
        neg(); chk("sim c6 valid", bus_valid, 0);

        // wait states on an IF fetch
        nxt(); if_req = 1; if_addr = 32'h0; bus_ready = 0;
        neg(); chk("ws c0 stall", bus_stall, 1);
        for (int i = 1; i <= 5; i++) begin
            nxt(); neg();
            chk("ws valid", bus_valid, 1); chk("ws addr", bus_addr, 0);
            chk("ws strb", bus_strb, 4'hF); chk("ws if_done", if_done, 0);
        end
        nxt(); bus_ready = 1; bus_rdata = 32'hCAFEF00D;
        neg(); chk("ws c6 valid", bus_valid, 1);
        nxt(); bus_ready = 0;
        neg(); chk("ws c7 if_done", if_done, 1); chk("ws c7 rdata", if_rdata, 32'hCAFEF00D);
        nxt(); if_req = 0;
        neg(); chk("ws c8 if_done", if_done, 0);

        // store
        nxt(); dm_req = 1; dm_we = 1; dm_wstrb = 4'b0011; dm_addr = 32'h300;
        dm_wdata = 32'h1234ABCD; bus_ready = 1; bus_rdata = 32'h55555555;
        nxt(); neg(); chk("st write", bus_write, 1); chk("st strb", bus_strb, 4'b0011);
        chk("st wdata", bus_wdata, 32'h1234ABCD); chk("st addr", bus_addr, 32'h300);
        nxt(); neg(); chk("st done", dm_done, 1); chk("st dm_rdata", dm_rdata, 32'h11111111);
        nxt(); dm_req = 0; dm_we = 0; bus_ready = 0;

        // jump during a stalled IF access
        nxt(); if_req = 1; if_addr = 32'h80;
        neg(); chk("jmp c0 flush", jump_flush, 0);
        nxt(); jump_req = 1;
        neg(); chk("jmp c1 flush", jump_flush, 0); chk("jmp c1 stall", bus_stall, 1);
        nxt(); jump_req = 0; bus_ready = 1; bus_rdata = 32'h0BADF00D;
        neg(); chk("jmp c2 flush", jump_flush, 0);
        nxt(); bus_ready = 0;
        neg(); chk("jmp c3 stall", bus_stall, 0); chk("jmp c3 flush", jump_flush, 1);
        nxt(); if_req = 0;
        neg(); chk("jmp c4 flush", jump_flush, 0);

        // asynchronous reset mid MEM access
        nxt(); dm_req = 1; dm_we = 0; dm_addr = 32'h400; bus_ready = 0;
        nxt(); neg(); chk("ar valid before", bus_valid, 1);
        #2 rst = 0;
        #1 chk("ar valid async", bus_valid, 0);
        dm_req = 0;
        nxt(); rst = 1;
        for (int i = 0; i < 3; i++) begin
            nxt(); neg();
            chk("ar idle dm_done", dm_done, 0); chk("ar idle if_done", if_done, 0);
            chk("ar idle stall", bus_stall, 0);
        end

        // randomized traffic; requests only change when the pipeline advances
        for (int n = 0; n < 3000; n++) begin
            nxt();
            if (!m_stall_seen) begin
                if_req   = ($urandom_range(0, 2) != 0);
                if_addr  = $urandom;
                dm_req   = ($urandom_range(0, 1) != 0);
                dm_we    = ($urandom_range(0, 1) != 0);
                dm_wstrb = 4'($urandom_range(1, 15));
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end
            bus_ready = ($urandom_range(0, 2) != 0);
            bus_rdata = $urandom;
            jump_req  = ($urandom_range(0, 7) == 0);
        end
        nxt(); if_req = 0; dm_req = 0; jump_req = 0; bus_ready = 0;
        repeat (2) neg();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
